instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0, meaning the PC loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 addr_out  out  32  fetch address to instruction memory; equals PC register.
REQ-005 pc_plus1_in  in  32  addr_out+1 returned by instruction memory.
REQ-006 instr_in  in  32  instruction word for addr_out; memory updates it on falling clk edge, so it is valid at the next rising edge.
REQ-007 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-008 redirect_addr  in  32  target PC for redirect.
REQ-009 halt_req  in  1  stop fetching after current cycle.
REQ-010 if_valid  out  1  head buffer entry valid toward decode.
REQ-011 if_ready  in  1  decode accepts head entry.
REQ-012 if_instr  out  32  head entry instruction.
REQ-013 if_pc  out  32  head entry PC.
REQ-014 if_pc1  out  32  head entry PC+1 (as returned by memory).
REQ-015 perf_fetch_cnt, perf_stall_cnt  out  16 each  performance counters (see Configuration).

Function
REQ-016 State machine SHALL have states FETCH and HALT; reset enters FETCH.
REQ-017 Buffer SHALL be a 2-entry FIFO of {pc, pc1, instr}; count in 0..2.
REQ-018 pop SHALL occur when if_valid && if_ready; if_valid = (count != 0); if_* driven from head entry, zero when empty.
REQ-019 push SHALL occur in FETCH when no redirect and (count < 2 or pop); push stores {addr_out, pc_plus1_in, instr_in} and loads PC <= pc_plus1_in.
REQ-020 Simultaneous push and pop at count==2 or count==1 SHALL keep count unchanged and preserve order.
REQ-021 No push SHALL occur when full without pop; PC SHALL hold (stall).
REQ-022 redirect_valid SHALL have priority over push, pop and halt: FIFO flushed (count=0, if_valid=0 next cycle), PC <= redirect_addr, state -> FETCH; pop in that cycle is ignored.
REQ-023 First push after redirect SHALL occur the following cycle (one bubble), with pc = redirect_addr.
REQ-024 halt_req in FETCH without redirect SHALL suppress push that cycle and move to HALT; HALT holds PC, performs no push, still drains FIFO via pops; only redirect leaves HALT.
REQ-025 PC arithmetic SHALL be 32-bit and wrap 32'hFFFFFFFF -> 0 as supplied by pc_plus1_in; no range check against memory depth.

Reset
REQ-026 rst SHALL set PC=RESET_PC, count=0, state=FETCH, if_valid=0, if_instr/if_pc/if_pc1=0, both perf counters=0.
REQ-027 rst asserted mid-operation SHALL discard buffered entries and pending redirect/halt; first push occurs the cycle after rst deasserts with pc=RESET_PC.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments per push, perf_stall_cnt per FETCH-state cycle with count==2 and no pop; both saturate at 16'hFFFF and clear on rst.
REQ-029 Macro FETCH_PERF_CNT_EN undefined: counter logic absent; perf_fetch_cnt and perf_stall_cnt SHALL be tied to 0.

Verification
REQ-030 Reset then if_ready=1 constant, memory model ADD at 0, SUB at 1 -> if_pc 0,1,2... on consecutive cycles from cycle 2, if_instr matches, addr_out increments each cycle.
REQ-031 if_ready=0 for 5 cycles -> count reaches 2, addr_out holds at 2, if_pc stays 0; perf_stall_cnt=3 (macro on); on if_ready=1 entries 0,1 then 2 emerge in order.
REQ-032 redirect_valid with redirect_addr=20 while count=2 -> next cycle if_valid=0, addr_out=20; following cycle if_pc=20 and JMR word at if_instr.
REQ-033 halt_req pulse at addr 5 with if_ready=1 -> entries up to 4 drain, addr_out stays 5, no further pushes; redirect to 9 resumes with if_pc=9.
REQ-034 rst asserted with count=2 -> next cycle if_valid=0, addr_out=RESET_PC, perf counters 0; PC wrap: redirect to 32'hFFFFFFFF with pc_plus1_in=0 -> following addr_out=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch stage. Drives a fetch address to instruction memory and
//   captures each returned {pc, pc+1, instr} into a 2-entry FIFO feeding decode.
//   Supports redirect (flush + refetch) and a halt that stops fetching while
//   still letting the FIFO drain. Redirect has priority over push, pop and halt.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   addr_out          fetch address (the PC register)
//   pc_plus1_in       addr_out+1 as returned by memory (source of next PC)
//   instr_in          instruction word for addr_out (valid at next rising edge)
//   redirect_valid    taken branch/jump: flush FIFO, PC <= redirect_addr
//   redirect_addr     redirect target
//   halt_req          stop fetching after the current cycle
//   if_valid/if_ready head-entry handshake toward decode
//   if_instr/if_pc/if_pc1  head-entry fields, zero when the FIFO is empty
//   perf_fetch_cnt    saturating push counter        (FETCH_PERF_CNT_EN)
//   perf_stall_cnt    saturating full-stall counter  (FETCH_PERF_CNT_EN)
//
// Configuration:
//   FETCH_PERF_CNT_EN  when defined, the performance counters are built;
//                      otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr_out,
    input  logic [31:0] pc_plus1_in,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc1,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
);

    typedef enum logic {FETCH, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [1:0]  count;
    logic        push, pop;
    logic        wr_head;

    // FIFO storage: e0 is the head entry, e1 the tail when two are held.
    logic [31:0] e0_pc, e0_pc1, e0_instr;
    logic [31:0] e1_pc, e1_pc1, e1_instr;

    assign addr_out = pc;
    assign if_valid = (count != 2'd0);
    assign if_pc    = if_valid ? e0_pc    : 32'd0;
    assign if_pc1   = if_valid ? e0_pc1   : 32'd0;
    assign if_instr = if_valid ? e0_instr : 32'd0;

    // Next state and FIFO strobes. A redirect suppresses everything else,
    // including the pop decode would otherwise take this cycle.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        if (redirect_valid) begin
            state_nxt = FETCH;
        end else begin
            pop = if_valid && if_ready;
            if (state == FETCH) begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else begin
                    push = (count != 2'd2) || pop;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            count <= 2'd0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc    <= redirect_addr;
                count <= 2'd0;
            end else begin
                if (push) pc <= pc_plus1_in;
                if (push && !pop)      count <= count + 2'd1;
                else if (pop && !push) count <= count - 2'd1;
            end
        end
    end

    // A new entry lands in the head slot when the FIFO is empty, or when the
    // single held entry leaves in the same cycle; otherwise it goes behind it.
    assign wr_head = (count == 2'd0) || ((count == 2'd1) && pop);

    always_ff @(posedge clk) begin
        if (pop) begin
            e0_pc    <= e1_pc;
            e0_pc1   <= e1_pc1;
            e0_instr <= e1_instr;
        end
        if (push) begin
            if (wr_head) begin
                e0_pc    <= pc;
                e0_pc1   <= pc_plus1_in;
                e0_instr <= instr_in;
            end else begin
                e1_pc    <= pc;
                e1_pc1   <= pc_plus1_in;
                e1_instr <= instr_in;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt;
    logic        stall_cycle;

    // Full FIFO in FETCH with decode not taking the head entry.
    assign stall_cycle = (state == FETCH) && (count == 2'd2) && !(if_valid && if_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (push && (fetch_cnt != 16'hFFFF))        fetch_cnt <= fetch_cnt + 16'd1;
            if (stall_cycle && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = 16'd0;
    assign perf_stall_cnt = 16'd0;
`endif

endmodule
